hyperram_target: RTL and testbench



---
 rtl/hyperram_pkg.sv | 47 ++++
 rtl/hyperram_target_mem.sv | 21 ++
 rtl/hyperram_target.sv | 151 +++++++++++++++
 tb/tb_hyperram_target.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hyperram_pkg.sv
// Shared constants, register map, state encoding and CR0 field decoders
// for the HyperRAM responder model.
package hyperram_pkg;

  // Command-address bit positions (48-bit CA word)
  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;
  localparam int CA_HI_LSB = 32;

  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;
  localparam logic [15:0] CR1_DEFAULT = 16'hFFC1;

  localparam logic [11:0] REG_ID0 = 12'h000;
  localparam logic [11:0] REG_ID1 = 12'h001;
  localparam logic [11:0] REG_CR0 = 12'h800;
  localparam logic [11:0] REG_CR1 = 12'h801;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CA    = 3'd1;
  localparam state_t ST_LAT   = 3'd2;
  localparam state_t ST_RDATA = 3'd3;
  localparam state_t ST_WDATA = 3'd4;
  localparam state_t ST_REGWR = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

  function automatic logic [3:0] latency_decode(input logic [3:0] code);
    case (code)
      4'h0:    return 4'd5;
      4'h1:    return 4'd6;
      4'hE:    return 4'd3;
      4'hF:    return 4'd4;
      default: return 4'd6;
    endcase
  endfunction

  function automatic logic [2:0] wrap_bits(input logic [1:0] code);
    case (code)
      2'b00:   return 3'd6;
      2'b01:   return 3'd5;
      2'b10:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/hyperram_target_mem.sv
// Single-port word RAM with per-byte write enables and registered read
// (read-before-write on a simultaneous access).
module hyperram_target_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hyperram_target.sv
// HyperRAM responder on the 16-bit word side: CA decode, CR0/CR1/ID registers,
// initial latency and linear/wrapped bursts against an internal byte-masked RAM.
module hyperram_target
  import hyperram_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] ID1_VAL = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic [15:0] dq_in,
  input  logic [1:0]  rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [1:0]  rwds_out,
  output logic        rwds_oe
);

  state_t            state;
  logic [4:0]        cnt;
  logic [15:0]       ca_hi, ca_mid, cr0, cr1, ram_q, reg_rd;
  logic              rd, linear;
  logic [4:0]        ltot, ltot_now;
  logic [2:0]        wbits;
  logic [ADDR_W-1:0] addr, ca_addr, ram_addr;
  logic [11:0]       reg_addr;
  logic [31:0]       word_addr;
  logic              data_phase, adv, unused_ok;
  logic [1:0]        mem_we;

  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a,
                                             input logic lin, input logic [2:0] b);
    logic [ADDR_W-1:0] inc, mask;
    inc  = a + 1'b1;
    mask = ADDR_W'((32'd1 << b) - 32'd1);
    return lin ? inc : ((a & ~mask) | (inc & mask));
  endfunction

  // Final CA word is still on dq_in at index 2, so the address is formed live there.
  assign word_addr = {ca_hi[12:0], ca_mid, dq_in[2:0]};
  assign ca_addr   = word_addr[ADDR_W-1:0];
  assign unused_ok = ^word_addr;
  assign ltot_now  = cr0[3] ? {latency_decode(cr0[7:4]), 1'b0}
                            : {1'b0, latency_decode(cr0[7:4])};

  assign data_phase = (state == ST_LAT || state == ST_RDATA || state == ST_WDATA)
                      && cnt >= ltot;
  // Reads run one word ahead to cover the RAM's registered output.
  assign adv      = rd ? (({1'b0, cnt} + 6'd1) >= {1'b0, ltot}) : (cnt >= ltot);
  assign mem_we   = (!rst && !csn && data_phase && !rd) ? ~rwds_in : 2'b00;
  assign ram_addr = (state == ST_CA) ? ca_addr : addr;

  always_comb begin
    reg_rd = '0;
    case (reg_addr)
      REG_ID0: reg_rd = ID0_VAL;
      REG_ID1: reg_rd = ID1_VAL;
      REG_CR0: reg_rd = cr0;
      REG_CR1: reg_rd = cr1;
      default: reg_rd = '0;
    endcase
  end

  hyperram_target_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (mem_we),
    .wdata (dq_in),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= '0;
      rwds_oe  <= 1'b0;
      cr0      <= CR0_DEFAULT;
      cr1      <= CR1_DEFAULT;
    end else if (csn) begin
      state    <= ST_IDLE;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= '0;
      rwds_oe  <= 1'b0;
    end else begin
      if (cnt != '1) cnt <= cnt + 5'd1;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= '0;
      rwds_oe  <= 1'b0;
      case (state)
        ST_IDLE: begin
          ca_hi <= dq_in;
          cnt   <= 5'd1;
          state <= ST_CA;
        end
        ST_CA: begin
          rwds_oe  <= 1'b1;
          rwds_out <= {2{cr0[3]}};
          if (cnt == 5'd1) begin
            ca_mid <= dq_in;
          end else begin
            rd       <= ca_hi[CA_RW-CA_HI_LSB];
            linear   <= ca_hi[CA_BT-CA_HI_LSB];
            ltot     <= ltot_now;
            wbits    <= wrap_bits(cr0[1:0]);
            reg_addr <= word_addr[11:0];
            // At the minimum latency the first RAM read is issued on this edge.
            addr <= (ca_hi[CA_RW-CA_HI_LSB] && !ca_hi[CA_AS-CA_HI_LSB] && ltot_now == 5'd3)
                    ? step(ca_addr, ca_hi[CA_BT-CA_HI_LSB], wrap_bits(cr0[1:0])) : ca_addr;
            state <= (!ca_hi[CA_RW-CA_HI_LSB] && ca_hi[CA_AS-CA_HI_LSB]) ? ST_REGWR : ST_LAT;
          end
        end
        ST_REGWR: begin
          if (reg_addr == REG_CR0)      cr0 <= dq_in;
          else if (reg_addr == REG_CR1) cr1 <= dq_in;
          state <= ST_DONE;
        end
        ST_DONE: ;
        ST_LAT, ST_RDATA, ST_WDATA: begin
          if (adv) addr <= step(addr, linear, wbits);
          if (data_phase) begin
            state <= rd ? ST_RDATA : ST_WDATA;
            if (rd) begin
              dq_out   <= (state != ST_IDLE && reg_addr_sel()) ? reg_rd : ram_q;
              dq_oe    <= 1'b1;
              rwds_out <= 2'b10;
              rwds_oe  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register-space flag latched at index 2 alongside the other CA fields.
  logic is_reg;
  always_ff @(posedge clk)
    if (!rst && !csn && state == ST_CA && cnt != 5'd1) is_reg <= ca_hi[CA_AS-CA_HI_LSB];

  function automatic logic reg_addr_sel();
    return is_reg;
  endfunction

endmodule

// File: tb/tb_hyperram_target.sv
// Directed bench for hyperram_target: register map, latency, RWDS during CA,
// linear/wrapped bursts, byte masking, csn abort and mid-burst reset.
module tb_hyperram_target;

  logic        clk = 1'b0;
  logic        rst, csn;
  logic [15:0] dq_in, dq_out;
  logic [1:0]  rwds_in, rwds_out;
  logic        dq_oe, rwds_oe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q [16];
  logic [15:0] wdat  [16];
  logic [1:0]  wmask [16];

  hyperram_target #(.ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .csn      (csn),
    .dq_in    (dq_in),
    .rwds_in  (rwds_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk_ca(input logic rd, input logic reg_sp,
                                        input logic lin, input logic [31:0] a);
    return {rd, reg_sp, lin, a[31:3], 13'd0, a[2:0]};
  endfunction

  task automatic start_ca(input logic [47:0] cav, input logic [1:0] rw);
    csn = 1'b0;
    dq_in = cav[47:32];
    tick();
    check("ca0_oe", {30'd0, dq_oe, rwds_oe}, 32'd0);
    dq_in = cav[31:16];
    tick();
    check("ca1_rwds", {29'd0, rwds_oe, rwds_out}, {29'd0, 1'b1, rw});
    dq_in = cav[15:0];
    tick();
    check("ca2_rwds", {29'd0, rwds_oe, rwds_out}, {29'd0, 1'b1, rw});
  endtask

  task automatic read_burst(input logic [47:0] cav, input int ltot,
                            input logic [1:0] rw, input int n);
    start_ca(cav, rw);
    for (int i = 3; i < ltot; i++) tick();
    check("pre_data", {31'd0, dq_oe}, 32'd0);
    for (int k = 0; k < n; k++) begin
      tick();
      check("rd_word", {12'd0, dq_oe, rwds_oe, rwds_out, dq_out},
            {12'd0, 1'b1, 1'b1, 2'b10, exp_q[k]});
    end
    csn = 1'b1;
    tick();
    check("rd_end", {30'd0, dq_oe, rwds_oe}, 32'd0);
  endtask

  task automatic write_burst(input logic [31:0] a, input int ltot, input logic [1:0] rw,
                             input int n, input int stop_at);
    start_ca(mk_ca(1'b0, 1'b0, 1'b1, a), rw);
    for (int i = 3; i < ltot; i++) tick();
    for (int k = 0; k < n; k++) begin
      dq_in   = wdat[k];
      rwds_in = wmask[k];
      if (k == stop_at) csn = 1'b1;
      tick();
      if (k == stop_at) begin
        check("abort_oe", {30'd0, dq_oe, rwds_oe}, 32'd0);
        break;
      end
    end
    csn = 1'b1;
    rwds_in = 2'b00;
    tick();
    check("wr_end", {30'd0, dq_oe, rwds_oe}, 32'd0);
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] rw);
    start_ca(mk_ca(1'b0, 1'b1, 1'b1, a), rw);
    dq_in = d;
    tick();
    dq_in = 16'hDEAD;
    tick();
    csn = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; csn = 1'b1; dq_in = '0; rwds_in = '0;
    for (int i = 0; i < 16; i++) wmask[i] = 2'b00;
    tick(); tick();
    check("rst_out", {12'd0, dq_oe, rwds_oe, rwds_out, dq_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Register reads at default latency (L=6, doubled -> 12)
    for (int k = 0; k < 3; k++) exp_q[k] = 16'h8F1F;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h800), 12, 2'b11, 3);
    exp_q[0] = 16'h0C81; exp_q[1] = 16'h0C81;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h000), 12, 2'b11, 2);
    exp_q[0] = 16'h0001;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h001), 12, 2'b11, 1);
    exp_q[0] = 16'hFFC1;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h801), 12, 2'b11, 1);
    exp_q[0] = 16'h0000;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h123), 12, 2'b11, 1);

    // CR0 <= 8FE7: L=3, single latency, 16-word wrap; extra word must be ignored
    reg_write(32'h800, 16'h8FE7, 2'b11);
    exp_q[0] = 16'h8FE7;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h800), 3, 2'b00, 1);

    // Linear write across the top of the array with a masked lower byte
    wdat[0] = 16'hABCD;
    write_burst(32'h3FF, 3, 2'b00, 1, -1);
    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
    wmask[1] = 2'b01;
    write_burst(32'h3FE, 3, 2'b00, 4, -1);
    wmask[1] = 2'b00;
    exp_q[0] = 16'h1111; exp_q[1] = 16'h22CD; exp_q[2] = 16'h3333; exp_q[3] = 16'h4444;
    read_burst(mk_ca(1'b1, 1'b0, 1'b1, 32'h3FE), 3, 2'b00, 4);
    exp_q[0] = 16'h3333; exp_q[1] = 16'h4444;
    read_burst(mk_ca(1'b1, 1'b0, 1'b1, 32'h000), 3, 2'b00, 2);

    // Wrapped read inside a 16-word group
    for (int i = 0; i < 16; i++) wdat[i] = 16'h5000 | 16'(i);
    write_burst(32'h000, 3, 2'b00, 16, -1);
    for (int k = 0; k < 10; k++) exp_q[k] = 16'h5000 | 16'((k + 14) & 15);
    read_burst(mk_ca(1'b1, 1'b0, 1'b0, 32'h00E), 3, 2'b00, 10);

    // csn rises on the edge of write word 2
    for (int i = 0; i < 4; i++) wdat[i] = 16'h7000 | 16'(i);
    write_burst(32'h020, 3, 2'b00, 4, -1);
    for (int i = 0; i < 4; i++) wdat[i] = 16'hA000 | 16'(i);
    write_burst(32'h020, 3, 2'b00, 4, 2);
    exp_q[0] = 16'hA000; exp_q[1] = 16'hA001; exp_q[2] = 16'h7002; exp_q[3] = 16'h7003;
    read_burst(mk_ca(1'b1, 1'b0, 1'b1, 32'h020), 3, 2'b00, 4);

    // Reset in the middle of a read burst
    start_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h000), 2'b00);
    tick();
    check("rst_rd0", {16'd0, dq_out}, 32'h5000);
    tick();
    check("rst_rd1", {16'd0, dq_out}, 32'h5001);
    rst = 1'b1;
    tick();
    check("rst_mid", {12'd0, dq_oe, rwds_oe, rwds_out, dq_out}, 32'd0);
    rst = 1'b0; csn = 1'b1;
    tick();
    exp_q[0] = 16'h8F1F;
    read_burst(mk_ca(1'b1, 1'b1, 1'b1, 32'h800), 12, 2'b11, 1);
    exp_q[0] = 16'h5000; exp_q[1] = 16'h5001;
    read_burst(mk_ca(1'b1, 1'b0, 1'b1, 32'h000), 12, 2'b11, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
